// File: rtl/pico_exec_core_p.sv
`default_nettype none
// =============================================================================
// pico_exec_core_p - 16-bit-instruction execution core, iterative shifter
// Revision: 1.0
// =============================================================================
module pico_exec_core_p #(
  parameter int XLEN    = 8,
  parameter int NREGS   = 8,
  parameter int PC_W    = 8,
  parameter int HOLDOFF = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [15:0]     instr_i,
  output logic            res_valid_o,
  output logic [2:0]      res_rd_o,
  output logic [XLEN-1:0] res_data_o,
  output logic [PC_W-1:0] pc_o,
  output logic            branch_taken_o,
  output logic            busy_o,
  input  logic [2:0]      dbg_sel_i,
  output logic [XLEN-1:0] dbg_data_o
);

  localparam int SW = $clog2(XLEN);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  generate
    if (NREGS != 8 || !(XLEN == 8 || XLEN == 16 || XLEN == 32) || PC_W < 6) begin : g_bad_params
      $error("pico_exec_core_p: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    SHIFT  = 3'd3,
    RETIRE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [SW-1:0]     sh_q, sh_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              busy_q, busy_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              res_valid_q, res_valid_d;
  logic [2:0]        res_rd_q, res_rd_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic              taken_q, taken_d;
  logic [XLEN-1:0]   rf_q [NREGS];
  logic              we;
  logic              cond;

  logic [1:0]        op;
  logic [2:0]        rd, rs1, rs2, f3;
  logic [4:0]        imm5;
  logic [XLEN-1:0]   imm_x;
  logic [PC_W-1:0]   off;

  assign op    = instr_q[1:0];
  assign rd    = instr_q[4:2];
  assign rs1   = instr_q[7:5];
  assign rs2   = instr_q[10:8];
  assign imm5  = instr_q[12:8];
  assign f3    = instr_q[15:13];
  assign imm_x = {{(XLEN-5){1'b0}}, imm5};
  assign off   = {{(PC_W-5){imm5[4]}}, imm5};

  always_comb begin
    cond = 1'b0;
    case (f3[1:0])
      2'b00:   cond = (a_q == b_q);
      2'b01:   cond = (a_q != b_q);
      2'b10:   cond = (a_q <  b_q);
      default: cond = (a_q >= b_q);
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_d         = alu_q;
    sh_d          = sh_q;
    hold_d        = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
    busy_d        = busy_q;
    pc_d          = pc_q;
    res_valid_d   = 1'b0;
    res_rd_d      = res_rd_q;
    res_data_d    = res_data_q;
    taken_d       = taken_q;
    we            = 1'b0;
    instr_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready_o = (hold_q == '0) && rst_n;
        if (instr_valid_i && instr_ready_o) begin
          instr_d = instr_i;
          busy_d  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rf_q[rs1];
        b_d     = rf_q[rs2];
        state_d = EXEC;
      end
      EXEC: begin
        state_d = RETIRE;
        case (op)
          2'b00: begin
            case (f3)
              3'b000:  alu_d = a_q + b_q;
              3'b001:  alu_d = a_q - b_q;
              3'b010:  alu_d = a_q & b_q;
              3'b011:  alu_d = a_q | b_q;
              3'b100:  alu_d = a_q ^ b_q;
              3'b101, 3'b110: begin
                alu_d   = a_q;
                sh_d    = b_q[SW-1:0];
                state_d = SHIFT;
              end
              default: alu_d = XLEN'(a_q < b_q);
            endcase
          end
          2'b01: begin
            case (f3)
              3'b000:  alu_d = a_q + imm_x;
              3'b010:  alu_d = XLEN'(a_q < imm_x);
              3'b011:  alu_d = a_q & imm_x;
              3'b100:  alu_d = a_q | imm_x;
              default: alu_d = imm_x;
            endcase
          end
          2'b10:   alu_d = rf_q[rd];
          default: alu_d = '0;
        endcase
      end
      SHIFT: begin
        // A zero count still spends one cycle here, so latency is max(shamt,1).
        if (sh_q != '0) begin
          alu_d = (f3 == 3'b101) ? (alu_q << 1) : (alu_q >> 1);
          sh_d  = sh_q - SW'(1);
        end
        if (sh_q <= SW'(1)) state_d = RETIRE;
      end
      RETIRE: begin
        res_valid_d = 1'b1;
        res_rd_d    = rd;
        busy_d      = 1'b0;
        state_d     = IDLE;
        if (op == 2'b11) begin
          taken_d    = cond;
          pc_d       = cond ? pc_q + off : pc_q + PC_W'(1);
          res_data_d = '0;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (op == 2'b10) begin
            res_data_d = alu_q;
          end else begin
            we         = (rd != 3'd0);
            res_data_d = we ? alu_q : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      sh_q        <= '0;
      hold_q      <= HW'(HOLDOFF);
      busy_q      <= 1'b0;
      pc_q        <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      taken_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      pc_q        <= pc_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      taken_q     <= taken_d;
      if (we) rf_q[rd] <= alu_q;
    end
  end

  assign res_valid_o    = res_valid_q;
  assign res_rd_o       = res_rd_q;
  assign res_data_o     = res_data_q;
  assign pc_o           = pc_q;
  assign branch_taken_o = taken_q;
  assign busy_o         = busy_q;
  assign dbg_data_o     = (dbg_sel_i == 3'd0) ? '0 : rf_q[dbg_sel_i];

endmodule
`default_nettype wire

// File: tb/tb_pico_exec_core_p.sv
`default_nettype none
// Directed bench for pico_exec_core_p: an XLEN=8 and an XLEN=16 instance run
// the same instruction stream and are checked against hand-computed values.
module tb_pico_exec_core_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  dbg_sel;

  logic        rdy8, rv8, tk8, busy8;
  logic [2:0]  rd8;
  logic [7:0]  data8, pc8, dbg8;
  logic        rdy16, rv16, tk16, busy16;
  logic [2:0]  rd16;
  logic [15:0] data16, dbg16;
  logic [7:0]  pc16;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_pc;
  logic        exp_tk;
  logic [4:0]  im;

  always #5 clk = ~clk;

  pico_exec_core_p #(.XLEN(8), .NREGS(8), .PC_W(8), .HOLDOFF(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(rdy8),
    .instr_i(instr), .res_valid_o(rv8), .res_rd_o(rd8), .res_data_o(data8),
    .pc_o(pc8), .branch_taken_o(tk8), .busy_o(busy8), .dbg_sel_i(dbg_sel),
    .dbg_data_o(dbg8)
  );

  pico_exec_core_p #(.XLEN(16), .NREGS(8), .PC_W(8), .HOLDOFF(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(rdy16),
    .instr_i(instr), .res_valid_o(rv16), .res_rd_o(rd16), .res_data_o(data16),
    .pc_o(pc16), .branch_taken_o(tk16), .busy_o(busy16), .dbg_sel_i(dbg_sel),
    .dbg_data_o(dbg16)
  );

  function automatic logic [15:0] ins(input logic [2:0] f3, input logic [4:0] imm,
                                      input logic [2:0] rs1, input logic [2:0] rd,
                                      input logic [1:0] op);
    return {f3, imm, rs1, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] w);
    int n;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    while (!rdy8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] w, input logic [15:0] e8, input logic [15:0] e16,
                     input int elat);
    int lat;
    start(w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv8 && lat < 40);
    if (w[1:0] != 2'b11) exp_pc = exp_pc + 8'd1;
    chk("latency", lat, elat);
    chk("res_valid16", rv16, 1);
    chk("pc8", pc8, exp_pc);
    chk("pc16", pc16, exp_pc);
    chk("taken8", tk8, exp_tk);
    chk("taken16", tk16, exp_tk);
    chk("res_rd8", rd8, w[4:2]);
    chk("busy8", busy8, 0);
    if (w[1:0] != 2'b11) begin
      chk("res_data8", data8, e8);
      chk("res_data16", data16, e16);
      chk("res_rd16", rd16, w[4:2]);
    end
  endtask

  task automatic dbg(input logic [2:0] s, input logic [15:0] e8, input logic [15:0] e16);
    dbg_sel = s;
    #1;
    chk("dbg8", dbg8, e8);
    chk("dbg16", dbg16, e16);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and hold-off with instr_valid held high
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = ins(3'b111, 5'd5, 3'd0, 3'd1, 2'b01);
    dbg_sel     = 3'd1;
    exp_pc      = 8'd0;
    exp_tk      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready8", rdy8, 0);
    chk("rst_ready16", rdy16, 0);
    chk("rst_res_valid", rv8, 0);
    chk("rst_pc", pc8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_taken", tk8, 0);
    chk("rst_data8", data8, 0);
    chk("rst_data16", data16, 0);
    chk("rst_rd", rd8, 0);
    chk("rst_dbg8", dbg8, 0);
    chk("rst_dbg16", dbg16, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("holdoff8", rdy8, (i == 3));
      chk("holdoff16", rdy16, (i == 3));
    end
    @(negedge clk);
    chk("accept_busy", busy8, 1);
    chk("accept_ready", rdy8, 0);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("li_early1", rv8, 0);
    @(negedge clk);
    chk("li_early2", rv8, 0);
    @(negedge clk);
    chk("li_valid", rv8, 1);
    chk("li_data8", data8, 8'h05);
    chk("li_data16", data16, 16'h0005);
    chk("li_rd", rd8, 1);
    chk("li_pc", pc8, 1);
    @(negedge clk);
    chk("li_pulse", rv8, 0);
    dbg(3'd1, 16'h05, 16'h05);
    exp_pc = 8'd1;

    // ADD x2 = x1 + x1
    run(ins(3'b000, 5'd1, 3'd1, 3'd2, 2'b00), 16'h0A, 16'h0A, 4);
    chk("ready_at_retire", rdy8, 1);
    dbg(3'd2, 16'h0A, 16'h0A);
    @(negedge clk);
    chk("add_pulse", rv8, 0);
    chk("add_hold", data8, 8'h0A);

    // Shifts
    run(ins(3'b111, 5'd31, 3'd0, 3'd1, 2'b01), 16'h1F, 16'h1F, 4);
    run(ins(3'b111, 5'd4, 3'd0, 3'd3, 2'b01), 16'h04, 16'h04, 4);
    run(ins(3'b101, 5'd3, 3'd1, 3'd4, 2'b00), 16'hF0, 16'h1F0, 8);
    run(ins(3'b101, 5'd0, 3'd1, 3'd5, 2'b00), 16'h1F, 16'h1F, 5);
    run(ins(3'b110, 5'd3, 3'd4, 3'd6, 2'b00), 16'h0F, 16'h1F, 8);
    dbg(3'd4, 16'hF0, 16'h1F0);

    // Arithmetic, compares, immediates, x0, read-back
    run(ins(3'b111, 5'd0, 3'd0, 3'd1, 2'b01), 16'h00, 16'h0000, 4);
    run(ins(3'b111, 5'd1, 3'd0, 3'd2, 2'b01), 16'h01, 16'h0001, 4);
    run(ins(3'b001, 5'd2, 3'd1, 3'd3, 2'b00), 16'hFF, 16'hFFFF, 4);
    run(ins(3'b111, 5'd3, 3'd2, 3'd5, 2'b00), 16'h01, 16'h0001, 4);
    run(ins(3'b000, 5'd7, 3'd2, 3'd0, 2'b01), 16'h00, 16'h0000, 4);
    dbg(3'd0, 16'h00, 16'h0000);
    run(ins(3'b100, 5'd5, 3'd3, 3'd6, 2'b00), 16'hFE, 16'hFFFE, 4);
    run(ins(3'b010, 5'd6, 3'd3, 3'd7, 2'b00), 16'hFE, 16'hFFFE, 4);
    run(ins(3'b011, 5'd5, 3'd7, 3'd7, 2'b00), 16'hFF, 16'hFFFF, 4);
    run(ins(3'b010, 5'd5, 3'd2, 3'd7, 2'b01), 16'h01, 16'h0001, 4);
    run(ins(3'b100, 5'h12, 3'd1, 3'd7, 2'b01), 16'h12, 16'h0012, 4);
    run(ins(3'b011, 5'h1C, 3'd3, 3'd7, 2'b01), 16'h1C, 16'h001C, 4);
    run(ins(3'b000, 5'd2, 3'd3, 3'd7, 2'b01), 16'h01, 16'h0001, 4);
    run(ins(3'b000, 5'd0, 3'd0, 3'd3, 2'b10), 16'hFF, 16'hFFFF, 4);
    dbg(3'd3, 16'hFF, 16'hFFFF);

    // Branches: first move pc to 10 with an always-equal BEQ
    im = 5'(8'd10 - exp_pc);
    exp_pc = 8'd10; exp_tk = 1'b1;
    run(ins(3'b000, im, im[2:0], 3'd0, 2'b11), 0, 0, 4);
    exp_pc = 8'd8;  exp_tk = 1'b1;
    run(ins(3'b000, 5'h1E, 3'd6, 3'd0, 2'b11), 0, 0, 4);
    exp_pc = 8'd9;  exp_tk = 1'b0;
    run(ins(3'b001, 5'h1E, 3'd6, 3'd0, 2'b11), 0, 0, 4);
    exp_pc = 8'd12; exp_tk = 1'b1;
    run(ins(3'b010, 5'h03, 3'd1, 3'd0, 2'b11), 0, 0, 4);
    exp_pc = 8'd13; exp_tk = 1'b0;
    run(ins(3'b011, 5'h03, 3'd1, 3'd0, 2'b11), 0, 0, 4);
    exp_pc = 8'd14; exp_tk = 1'b1;
    run(ins(3'b011, 5'h01, 3'd3, 3'd0, 2'b11), 0, 0, 4);
    exp_pc = 8'd9;  exp_tk = 1'b1;
    run(ins(3'b001, 5'h1B, 3'd1, 3'd0, 2'b11), 0, 0, 4);

    // pc wrap at 0xFF
    while (exp_pc != 8'hFF) run(ins(3'b000, 5'd0, 3'd0, 3'd0, 2'b10), 0, 0, 4);
    run(ins(3'b000, 5'd0, 3'd0, 3'd0, 2'b10), 0, 0, 4);
    chk("pc_wrapped", pc8, 0);

    // Reset during SHIFT aborts the instruction
    run(ins(3'b111, 5'd3, 3'd0, 3'd1, 2'b01), 16'h03, 16'h03, 4);
    run(ins(3'b111, 5'd4, 3'd0, 3'd3, 2'b01), 16'h04, 16'h04, 4);
    start(ins(3'b101, 5'd3, 3'd1, 3'd4, 2'b00));
    repeat (3) @(negedge clk);
    chk("shift_busy", busy8, 1);
    chk("shift_no_result", rv8, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy8", busy8, 0);
    chk("abort_busy16", busy16, 0);
    chk("abort_valid", rv8, 0);
    chk("abort_pc", pc8, 0);
    chk("abort_data", data16, 0);
    dbg(3'd3, 16'h00, 16'h0000);
    dbg(3'd4, 16'h00, 16'h0000);
    rst_n  = 1'b1;
    exp_pc = 8'd0;
    exp_tk = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("re_holdoff8", rdy8, (i == 3));
      chk("re_no_result", rv8, 0);
    end
    run(ins(3'b111, 5'd9, 3'd0, 3'd1, 2'b01), 16'h09, 16'h09, 4);
    dbg(3'd1, 16'h09, 16'h09);
    dbg(3'd4, 16'h00, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pico_exec_core_p.md
Name: pico_exec_core_p

Overview:
Parametrised successor of the 8-bit pico execution core. It executes one 16-bit instruction at a time against an NREGS x XLEN register file, where x0 is hardwired to zero. Instructions are delivered through a valid/ready handshake instead of a level strobe. The block adds an iterative multi-cycle shifter, correctly resolved branches, a registered result strobe and an independent register read-back port. It sits behind the pin-level wrapper, which maps ui_in/uio_in onto the instruction port.

Parameters:
XLEN, 8, data and register width in bits; legal values 8, 16, 32.
NREGS, 8, register count; fixed at 8 by the 3-bit register fields, and elaboration fails otherwise.
PC_W, 8, program counter width; wraps modulo 2^PC_W.
HOLDOFF, 3, cycles after reset release before instr_ready may assert.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
instr_valid  in  1  instruction offered.
instr_ready  out  1  core can accept an instruction.
instr  in  16  instruction word.
res_valid  out  1  one-cycle strobe: an instruction has retired.
res_rd  out  3  destination field of the retired instruction.
res_data  out  XLEN  value written, or value read for opcode 10.
pc  out  PC_W  program counter.
branch_taken  out  1  the last retired branch was taken.
busy  out  1  high from accept until retire.
dbg_sel  in  3  read-back register select.
dbg_data  out  XLEN  registers[dbg_sel], combinational; x0 reads 0.

Behaviour:
- Reset value of every output and internal register is 0: registers, pc, res_*, branch_taken, busy, hold-off counter = HOLDOFF. The exception is instr_ready, which is 0 during reset. Reset asserted mid-instruction aborts it with no writeback.
- Instruction fields: [1:0] op, [4:2] rd, [7:5] rs1, [10:8] rs2, [12:8] imm5, [15:13] f3.
- imm5 is zero-extended to XLEN. Branch offset is imm5 sign-extended to PC_W.
- State machine states: IDLE, DECODE, EXEC, SHIFT, RETIRE.
- IDLE: instr_ready = (hold-off count == 0). Transfer occurs when instr_valid && instr_ready; the word is latched, busy is set and the state goes to DECODE. instr_ready is 0 in every other state.
- DECODE: latch A = reg[rs1], B = reg[rs2]; go to EXEC.
- EXEC, op 00 (R-type), f3 selects:
  - ADD, SUB, AND, OR, XOR, each modulo 2^XLEN.
  - SLL and SRL: shift count = B mod XLEN; go to SHIFT.
  - SLTU: result is 1 or 0.
- EXEC, op 01 (I-type), f3 selects:
  - 000 ADDI; 010 SLTIU; 011 ANDI; 100 ORI.
  - Any other f3: load immediate (LI).
- EXEC, op 10: read-back. No register write; res_data = reg[rd].
- EXEC, op 11 (branch), f3[1:0] selects: 00 BEQ, 01 BNE, 10 BLTU, 11 BGEU.
  - The comparison uses this instruction's A and B, not a stale flag.
  - Taken: pc <= pc + offset. Not taken: pc <= pc + 1.
  - branch_taken updates at retire.
- SHIFT: one bit position per cycle while the shift count is nonzero. A count of 0 leaves SHIFT after one cycle with the result equal to A.
- RETIRE:
  - Write reg[rd] unless rd == 0 or op is 10/11.
  - Non-branch ops: pc <= pc + 1.
  - Pulse res_valid for exactly 1 cycle, with res_rd and res_data held until the next retire.
  - Clear busy and return to IDLE.
- Latency, with the transfer on edge N:
  - Non-shift ops: res_valid high in the cycle after edge N+3.
  - Shifts: same, plus max(shamt, 1) cycles.
  - The next transfer is possible on edge N+4 at the earliest.
- Writes to x0 are discarded, and x0 results report res_data = 0.
- dbg_data reflects a register write in the cycle after RETIRE.
- instr_valid held during busy is ignored; there is no queueing. A valid dropped before ready is lost, which is legal.

Test Plan:
1. Reset, then instr_valid held high → instr_ready low for exactly HOLDOFF cycles after rst_n rises; all outputs 0.
2. LI x1 = 5 (op 01, f3 111, rd 1, imm5 5), then ADD x2 = x1 + x1 → res_data 0x0A, res_rd 2, dbg_sel 2 reads 0x0A, pc = 2, res_valid 1 cycle each.
3. XLEN = 8: LI x1 = 31; LI x3 = 4; SLL x4 = x1 << x3 → res_data 0xF0; retire exactly 4 cycles later than a non-shift op; shamt 0 → result = x1.
4. SUB with x1 = 0, x2 = 1 at XLEN = 16 → 0xFFFF; SLTU x5 = 1 < 0xFFFF → 1; ADDI to rd 0 → x0 stays 0 and res_data 0.
5. pc = 10, BEQ with equal operands and imm5 = 0x1E (-2) → pc = 8, branch_taken 1. BNE with the same operands → pc + 1, branch_taken 0. pc = 0xFF with a non-branch op → wraps to 0.
6. rst_n pulsed low during SHIFT → no writeback, state IDLE, busy 0, registers 0; a new transfer is accepted after HOLDOFF cycles.
